// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave / RAM controller pair: command codes,
// controller FSM states and the default address/data width.
package spi_pkg;

    localparam int ADDR_SIZE_DEFAULT = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        TX_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port synchronous RAM, MEM_DEPTH words of ADDR_SIZE bits, registered read.
// Contents are never reset; addresses beyond MEM_DEPTH read as zero and ignore writes.
module spi_ram_array #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [ADDR_SIZE-1:0] din,
    output logic [ADDR_SIZE-1:0] dout
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] dout_q;
    logic [IDX_W-1:0]     idx;
    logic                 hit;

    assign idx  = addr[IDX_W-1:0];
    assign hit  = ({1'b0, addr} < DEPTH);
    assign dout = dout_q;

    always_ff @(posedge clk) begin
        if (we && hit) begin
            mem[idx] <= din;
        end
        dout_q <= hit ? mem[idx] : '0;
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM controller behind the SPI slave. Define SPI_RAM_AUTO_INC_EN
// to make the write/read pointers post-increment after every data access.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 addr_err
);

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return ({1'b0, a} < DEPTH);
    endfunction

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 addr_err_q, addr_err_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_oor_q, rd_oor_d;

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [ADDR_SIZE-1:0] ram_dout;

    assign cmd     = rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign payload = rx_data[ADDR_SIZE-1:0];

    spi_ram_array #(
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (payload),
        .dout(ram_dout)
    );

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        addr_err_d = addr_err_q;
        rd_pend_d  = 1'b0;
        rd_oor_d   = rd_oor_q;
        ram_we     = 1'b0;
        ram_addr   = rd_addr_q;

        // The RAM word read on the RD_DATA edge lands in the hold register one cycle later
        if (rd_pend_q && state_q == TX_HOLD) begin
            tx_data_d  = rd_oor_q ? '0 : ram_dout;
            tx_valid_d = 1'b1;
        end

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload;
                CMD_WR_DATA: begin
                    ram_addr = wr_addr_q;
                    if (in_range(wr_addr_q)) begin
                        ram_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC) begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
                CMD_RD_ADDR: rd_addr_d = payload;
                default: begin
                    rd_pend_d = 1'b1;
                    rd_oor_d  = !in_range(rd_addr_q);
                    if (!in_range(rd_addr_q)) begin
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            endcase

            if (cmd == CMD_RD_DATA) begin
                state_d = TX_HOLD;
            end else begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            addr_err_q <= addr_err_d;
            rd_pend_q  <= rd_pend_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus random command
// traffic compared every cycle against a behavioural model of the command set.
module tb_spi_ram_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 200;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW+1:0] rx_data;
    logic          rx_valid;
    logic [AW-1:0] tx_data;
    logic          tx_valid;
    logic          addr_err;

    int nCompared;
    int nMismatched;

    int m_mem [256];
    int m_wr, m_rd, m_tx, m_pendVal;
    bit m_txv, m_err, m_pend;

    spi_ram_ctrl #(
        .ADDR_SIZE(AW),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check is counted here and mismatches are reported
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_wr   = 0;
        m_rd   = 0;
        m_tx   = 0;
        m_txv  = 0;
        m_err  = 0;
        m_pend = 0;
    endtask

    // Reference behaviour for one rising edge: a read issued last edge becomes visible now,
    // then the command seen on this edge is applied
    task automatic modelEdge(input bit v, input int c, input int p);
        if (m_pend) begin
            m_tx   = m_pendVal;
            m_txv  = 1;
            m_pend = 0;
        end
        if (v) begin
            case (c)
                0: m_wr = p;
                1: begin
                    if (m_wr < DEPTH) m_mem[m_wr] = p;
                    else              m_err = 1;
                    if (AUTO_INC) m_wr = (m_wr + 1) % 256;
                end
                2: m_rd = p;
                default: begin
                    m_pend    = 1;
                    m_pendVal = (m_rd < DEPTH) ? m_mem[m_rd] : 0;
                    if (m_rd >= DEPTH) m_err = 1;
                    if (AUTO_INC) m_rd = (m_rd + 1) % 256;
                end
            endcase
            if (c != 3) m_txv = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("tx_valid", 32'(tx_valid), 32'(m_txv));
        checkOutput("tx_data",  32'(tx_data),  32'(m_tx));
        checkOutput("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge
    task automatic applyStimulus(input bit v, input int c, input int p);
        logic [1:0]    cb;
        logic [AW-1:0] pb;
        cb       = 2'(c);
        pb       = AW'(p);
        rx_valid = v;
        rx_data  = {cb, pb};
        @(posedge clk);
        modelEdge(v, c, p);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 10'($urandom);
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
    endtask

    task automatic randomTraffic(input int n, input int maxAddr);
        int c, p;
        for (int i = 0; i < n; i++) begin
            c = $urandom_range(0, 3);
            p = (c == 0 || c == 2) ? $urandom_range(0, maxAddr) : $urandom_range(0, 255);
            applyStimulus(1, c, p);
            idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        rst_n       = 1'b0;
        modelReset();

        repeat (2) @(negedge clk);
        checkAll();
        rst_n = 1'b1;
        idle(2);

        // Give every in-range word a known value
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1, 0, a);
            applyStimulus(1, 1, $urandom_range(0, 255));
        end

        // Write then read back with the hold period and release on the next WR_ADDR
        applyStimulus(1, 0, 'h12);
        applyStimulus(1, 1, 'hA5);
        applyStimulus(1, 2, 'h12);
        applyStimulus(1, 3, 0);
        idle(1);
        if (!AUTO_INC) checkOutput("read_a5", 32'(tx_data), 32'h0000_00A5);
        idle(8);
        applyStimulus(1, 0, 'h40);
        idle(2);

        // Two reads twelve cycles apart
        applyStimulus(1, 2, 'h12);
        applyStimulus(1, 3, 0);
        idle(11);
        applyStimulus(1, 3, 0);
        idle(3);
        applyStimulus(1, 0, 0);
        idle(1);

        // Burst around the top of the address space
        applyStimulus(1, 0, 'hFF);
        applyStimulus(1, 1, 'h11);
        applyStimulus(1, 1, 'h22);
        applyStimulus(1, 2, 'hFF);
        applyStimulus(1, 3, 0);
        idle(2);
        applyStimulus(1, 3, 0);
        idle(2);
        applyStimulus(1, 2, 0);
        applyStimulus(1, 3, 0);
        idle(2);

        // Reset clears any error from the burst before the in-range random phase
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        randomTraffic(150, DEPTH - 1);

        // Out-of-range write and read
        applyStimulus(1, 0, 'hC8);
        applyStimulus(1, 1, 'h33);
        checkOutput("err_after_wr", 32'(addr_err), 32'd1);
        applyStimulus(1, 2, 'hC8);
        applyStimulus(1, 3, 0);
        idle(2);
        checkOutput("oor_read_zero", 32'(tx_data), 32'd0);
        idle(3);

        // Asynchronous reset in the middle of a cycle while a read is being held
        applyStimulus(1, 3, 0);
        idle(2);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        applyStimulus(1, 3, 0);
        idle(2);

        randomTraffic(150, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data words (2-bit command + ADDR_SIZE payload) qualified by rx_valid.
- Returns read data to the slave on tx_data/tx_valid for serialization onto MISO.
- Holds separate write and read address pointers and flags out-of-range accesses.

Parameters:
ADDR_SIZE, 8, width of address and data payload; rx_data is ADDR_SIZE+2 bits
MEM_DEPTH, 256, number of words; must be 1..2**ADDR_SIZE

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  ADDR_SIZE+2  [ADDR_SIZE+1:ADDR_SIZE]=command, [ADDR_SIZE-1:0]=payload
rx_valid  input  1  single-cycle strobe, rx_data valid
tx_data  output  ADDR_SIZE  read data to SPI slave
tx_valid  output  1  tx_data valid, held until next rx_valid
addr_err  output  1  sticky: an address >= MEM_DEPTH was used

Behaviour:
- Reset (async, rst_n=0): wr_addr=0, rd_addr=0, tx_data=0, tx_valid=0, addr_err=0, FSM=IDLE. RAM contents not reset. Mid-operation reset aborts any pending read immediately.
- Commands are decoded only on cycles with rx_valid=1; rx_data is ignored otherwise:
  - 00 WR_ADDR: wr_addr <= payload.
  - 01 WR_DATA: mem[wr_addr] <= payload.
  - 10 RD_ADDR: rd_addr <= payload.
  - 11 RD_DATA: payload ignored; read mem[rd_addr].
- FSM states:
  - IDLE -> TX_HOLD on RD_DATA.
  - TX_HOLD -> IDLE on any rx_valid with a command other than RD_DATA.
  - TX_HOLD -> TX_HOLD on RD_DATA; tx_data is reloaded with fresh data.
- Read latency:
  - RD_DATA sampled at edge N; tx_data=mem[rd_addr] and tx_valid=1 after edge N+1 (registered RAM read). Exactly 1 cycle.
  - In TX_HOLD, tx_data is stable and tx_valid=1 for all cycles the slave needs to shift ADDR_SIZE bits.
  - tx_valid clears at the edge sampling the next non-RD_DATA rx_valid.
- RAM-port conflicts: WR_DATA and RD_DATA never coincide (one command per rx_valid). Read-after-write to the same address returns the new value.
- Range check, for any address use with wr_addr or rd_addr >= MEM_DEPTH:
  - A write is dropped.
  - A read returns tx_data=0 with tx_valid still asserted.
  - addr_err is set the edge after the offending command and stays set until reset.
- An address load (WR_ADDR or RD_ADDR) with an out-of-range payload does not itself set addr_err; only the access does.
- Pointer width is ADDR_SIZE; wrap-around is modulo 2**ADDR_SIZE.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - wr_addr increments by 1 after every WR_DATA, including dropped ones.
  - rd_addr increments by 1 after every RD_DATA.
  - Both pointers wrap 2**ADDR_SIZE-1 -> 0.
  - Burst writes/reads without reloading the address are supported.
- Undefined: pointers change only on WR_ADDR/RD_ADDR.
- No other behaviour differs.

Decomposition:
- Shared package spi_pkg:
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FSM state encodings IDLE/TX_HOLD.
  - Default ADDR_SIZE constant, shared with SPI_Slave.
- One sub-module: spi_ram_array.
  - Single-port synchronous RAM, MEM_DEPTH x ADDR_SIZE.
  - Ports: we, addr, din, registered dout.
  - Command decode, pointers, range check and FSM stay in spi_ram_ctrl.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> tx_valid=0, tx_data=0, addr_err=0 immediately, without waiting for a clock edge.
2. Write/read: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> tx_data=0xA5 and tx_valid=1 exactly one cycle after the RD_DATA strobe; both held until the next WR_ADDR strobe.
3. Back-to-back reads: two RD_DATA strobes 12 cycles apart, no intervening command (macro off) -> tx_valid stays 1 throughout; tx_data re-read, same value.
4. Auto-increment (SPI_RAM_AUTO_INC_EN): WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, RD_DATA, RD_DATA -> tx_data 0x11 then 0x22; mem[0x00]=0x22 (wrap).
5. Range error, MEM_DEPTH=200: WR_ADDR 0xC8, WR_DATA 0x33 -> addr_err=1 next cycle; RD_ADDR 0xC8, RD_DATA -> tx_data=0x00, tx_valid=1; addr_err remains 1.
6. Reset mid-read: RD_DATA, then rst_n low while tx_valid=1 -> tx_valid=0 at once. After release, RD_DATA reads mem[0] with RAM contents intact.
